heap_array_allocator: RTL and testbench
=======================================

Name: heap_array_allocator

Overview:
- Shared allocator for heap array slots. Arbitrates alloc/free requests from NReq program engines with round-robin.
- Hands out array indices with LIFO reuse from a freed-arrays stack. Falls back to the bump counter `allocs` when the stack is empty.
- Emits an array-size clear strobe for the `arraySizes` table on every successful alloc. Sits between the instruction engines and the heap/`arraySizes` storage.

Parameters:
- NReq, 2, number of requesting engines (≥1).
- NArrays, 4, maximum number of arrays (≥1).
- MemoryElementWidth, 12, width of an array index / heap element.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NReq  per-requester request; held high until the matching req_ready pulse.
- req_free  input  NReq  per-requester op: 0 = alloc, 1 = free.
- req_array  input  NReq*MemoryElementWidth  array to free; slice r belongs to requester r; ignored for alloc.
- req_ready  output  NReq  one-hot, one-cycle grant pulse; request captured on this edge.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_req  output  $clog2(NReq) (min 1)  index of the requester being answered.
- rsp_array  output  MemoryElementWidth  allocated index (alloc) or echoed index (free); 0 on alloc error.
- rsp_error  output  1  op failed; qualified by rsp_valid.
- size_clear  output  1  one-cycle strobe: set arraySizes[size_clear_array] to 0.
- size_clear_array  output  MemoryElementWidth  index to clear.
- allocs  output  MemoryElementWidth  arrays ever handed out by the bump counter (high-water mark).
- in_use  output  MemoryElementWidth  arrays currently allocated.

Behaviour:
- Synchronous reset: state=IDLE; req_ready=0, rsp_valid=0, rsp_error=0, rsp_req=0, rsp_array=0, size_clear=0, size_clear_array=0, allocs=0, in_use=0; freed stack top=0; in-use bitmap=0; round-robin pointer=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Round-robin pick among req_valid, starting at pointer; pointer = last granted requester + 1, mod NReq.
  - req_ready[g] is asserted combinationally in this cycle only.
  - Latch op, array and g; go to EXEC. If no request, stay in IDLE.
- EXEC, alloc:
  - If stack top>0: top--, result = freed[top].
  - Else if allocs<NArrays: result = allocs, allocs++.
  - Else: error, result = 0.
  - On success: set bitmap[result], in_use++, register size_clear=1 with size_clear_array=result.
- EXEC, free:
  - Error if array>=allocs or bitmap[array]==0 (out of range or double free). State unchanged on error.
  - Else: freed[top]=array, top++, clear bitmap[array], in_use--.
  - The stack cannot overflow: entries ≤ allocs ≤ NArrays; this is a verification assertion.
- RESP:
  - rsp_valid=1 for exactly one cycle with rsp_req, rsp_array, rsp_error.
  - size_clear is high in this same cycle for a successful alloc.
  - Next state is IDLE.
- Latency: grant at cycle t, rsp_valid at t+2. Next grant earliest at t+3, so throughput is one op per 3 cycles.
- Simultaneous requests: only one grant per IDLE cycle. Losers keep req_valid high. Every valid requester is granted within NReq grants.
- Requesters must not drop or change req_valid, req_free or req_array before req_ready. The bench asserts this.
- A requester may re-request in the cycle after its rsp_valid.
- allocs and in_use saturate nowhere; the bounds follow from the rules above. Arithmetic is unsigned at MemoryElementWidth.
- Reset mid-operation (EXEC or RESP): abort, no rsp_valid, all state cleared as at reset.

Decomposition:
- Package heap_alloc_pkg:
  - MemoryElementWidth default constant.
  - alloc_state_t enum {IDLE, EXEC, RESP}.
  - alloc_op_t enum {OP_ALLOC=0, OP_FREE=1}.
- One sub-module, rr_arbiter:
  - Parameter NReq; inputs clock, reset, req, advance.
  - Outputs grant (one-hot), grant_idx, any.
  - Owns the rotating pointer; advance is asserted on a taken grant.

Test Plan:
- After reset, requester 0 allocs twice -> rsp_array 0 then 1, rsp_error 0, size_clear with 0 then 1, allocs=2, in_use=2, rsp_valid exactly 2 cycles after each grant.
- Alloc 0,1,2; free 1; free 0; alloc; alloc -> results 0 then 1 (LIFO); allocs stays 3; in_use 3.
- NArrays=4: five allocs -> fifth gives rsp_error=1, rsp_array=0, no size_clear, allocs=4, in_use=4; then free 2 and alloc -> 2, no error.
- Free 3 when allocs=2 -> error. Alloc 0, free 0, free 0 again -> second free error; stack top stays 1, in_use 0.
- NReq=2, both requesters hold alloc continuously for 4 grants -> grants alternate 0,1,0,1; rsp_req matches; results 0,1,2,3.
- Assert reset in the EXEC cycle of an alloc -> no rsp_valid or size_clear; next alloc after reset returns 0 with allocs=1.

Source files
------------

// File: rtl/heap_array_allocator_pkg.sv
// Shared types and helpers for the heap array allocator.
package heap_alloc_pkg;

  // Default width of an array index / heap element.
  localparam int MEM_ELEM_WIDTH_DEFAULT = 12;

  // Allocator control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alloc_state_t;

  // Requested operation, matches the req_free encoding.
  typedef enum logic {
    OP_ALLOC = 1'b0,
    OP_FREE  = 1'b1
  } alloc_op_t;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/heap_array_allocator_if.sv
// Request/response bundle between program engines and the allocator.
interface heap_array_allocator_if
  import heap_alloc_pkg::*;
#(
  parameter int NReq               = 2,
  parameter int MemoryElementWidth = MEM_ELEM_WIDTH_DEFAULT
);
  localparam int IW = idx_width(NReq);

  logic [NReq-1:0]                    req_valid;
  logic [NReq-1:0]                    req_free;
  logic [NReq*MemoryElementWidth-1:0] req_array;
  logic [NReq-1:0]                    req_ready;
  logic                               rsp_valid;
  logic [IW-1:0]                      rsp_req;
  logic [MemoryElementWidth-1:0]      rsp_array;
  logic                               rsp_error;
  logic                               size_clear;
  logic [MemoryElementWidth-1:0]      size_clear_array;
  logic [MemoryElementWidth-1:0]      allocs;
  logic [MemoryElementWidth-1:0]      in_use;

  // Engine side: issues requests, observes responses and status.
  modport master (
    output req_valid, req_free, req_array,
    input  req_ready, rsp_valid, rsp_req, rsp_array, rsp_error,
    input  size_clear, size_clear_array, allocs, in_use
  );

  // Allocator side.
  modport slave (
    input  req_valid, req_free, req_array,
    output req_ready, rsp_valid, rsp_req, rsp_array, rsp_error,
    output size_clear, size_clear_array, allocs, in_use
  );

endinterface

// File: rtl/heap_array_allocator_rr_arbiter.sv
// Round-robin arbiter: the search starts at a rotating pointer which moves
// to one past the winner whenever the grant is actually taken.
module rr_arbiter
  import heap_alloc_pkg::*;
#(
  parameter  int NReq = 2,
  localparam int IW   = idx_width(NReq)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NReq-1:0] req,
  input  logic            advance,
  output logic [NReq-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  // First active request at or after the pointer, wrapping around.
  always_comb begin : pick
    int c;
    c         = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < NReq; k++) begin
      if (!any) begin
        c = int'(ptr_q) + k;
        if (c >= NReq) c = c - NReq;
        if (req[IW'(c)]) begin
          any       = 1'b1;
          grant_idx = IW'(c);
          grant     = NReq'(1) << c;
        end
      end
    end
  end

  // Pointer moves past the winner only when its grant is consumed.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && any) begin
      ptr_d = (grant_idx == IW'(NReq - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/heap_array_allocator.sv
// Heap array slot allocator: one op per three cycles (grant, execute,
// respond). Freed indices are reused LIFO; when none are free a bump
// counter hands out fresh ones up to NArrays.
module heap_array_allocator
  import heap_alloc_pkg::*;
#(
  parameter int NReq               = 2,
  parameter int NArrays            = 4,
  parameter int MemoryElementWidth = MEM_ELEM_WIDTH_DEFAULT
) (
  input logic                   clock,
  input logic                   reset,
  heap_array_allocator_if.slave bus
);

  localparam int W  = MemoryElementWidth;
  localparam int IW = idx_width(NReq);
  localparam int BW = idx_width(NArrays);
  localparam int TW = $clog2(NArrays + 1);
  localparam logic [W-1:0] ONE_W = W'(1);
  localparam logic [W-1:0] MAX_W = W'(NArrays);

  // Per-requester view of the flattened array bus.
  logic [W-1:0] req_arr [NReq];
  for (genvar gi = 0; gi < NReq; gi++) begin : g_unpack
    assign req_arr[gi] = bus.req_array[gi*W +: W];
  end

  // Arbiter.
  logic [NReq-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            arb_advance;

  rr_arbiter #(.NReq(NReq)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (bus.req_valid),
    .advance   (arb_advance),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // State.
  alloc_state_t       state_q, state_d;
  alloc_op_t          op_q, op_d;
  logic [W-1:0]       array_q, array_d;
  logic [IW-1:0]      req_q, req_d;
  logic [W-1:0]       allocs_q, allocs_d;
  logic [W-1:0]       in_use_q, in_use_d;
  logic [TW-1:0]      top_q, top_d;
  logic [NArrays-1:0] bitmap_q, bitmap_d;
  logic [W-1:0]       freed_q [NArrays];
  logic               push_en;
  logic [BW-1:0]      push_idx;
  logic [W-1:0]       push_val;

  logic               rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]      rsp_req_q, rsp_req_d;
  logic [W-1:0]       rsp_array_q, rsp_array_d;
  logic               rsp_error_q, rsp_error_d;
  logic               size_clear_q, size_clear_d;
  logic [W-1:0]       size_clear_array_q, size_clear_array_d;

  // Next-state and grant logic for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d            = state_q;
    op_d               = op_q;
    array_d            = array_q;
    req_d              = req_q;
    allocs_d           = allocs_q;
    in_use_d           = in_use_q;
    top_d              = top_q;
    bitmap_d           = bitmap_q;
    push_en            = 1'b0;
    push_idx           = BW'(top_q);
    push_val           = array_q;
    rsp_valid_d        = 1'b0;
    rsp_req_d          = rsp_req_q;
    rsp_array_d        = rsp_array_q;
    rsp_error_d        = rsp_error_q;
    size_clear_d       = 1'b0;
    size_clear_array_d = size_clear_array_q;
    arb_advance        = 1'b0;
    bus.req_ready      = '0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          bus.req_ready = arb_grant;
          arb_advance   = 1'b1;
          op_d          = alloc_op_t'(bus.req_free[arb_idx]);
          array_d       = req_arr[arb_idx];
          req_d         = arb_idx;
          state_d       = EXEC;
        end
      end

      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_req_d   = req_q;
        if (op_q == OP_ALLOC) begin
          rsp_error_d = 1'b0;
          if (top_q != '0) begin
            top_d       = top_q - TW'(1);
            rsp_array_d = freed_q[BW'(top_q - TW'(1))];
          end else if (allocs_q < MAX_W) begin
            rsp_array_d = allocs_q;
            allocs_d    = allocs_q + ONE_W;
          end else begin
            rsp_error_d = 1'b1;
            rsp_array_d = '0;
          end
          if (!rsp_error_d) begin
            bitmap_d[BW'(rsp_array_d)] = 1'b1;
            in_use_d                   = in_use_q + ONE_W;
            size_clear_d               = 1'b1;
            size_clear_array_d         = rsp_array_d;
          end
        end else begin
          rsp_array_d = array_q;
          // Out of range or not currently allocated (double free).
          if (array_q >= allocs_q || !bitmap_q[BW'(array_q)]) begin
            rsp_error_d = 1'b1;
          end else begin
            rsp_error_d              = 1'b0;
            push_en                  = 1'b1;
            top_d                    = top_q + TW'(1);
            bitmap_d[BW'(array_q)]   = 1'b0;
            in_use_d                 = in_use_q - ONE_W;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Control and status registers; reset aborts any op in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q            <= IDLE;
      op_q               <= OP_ALLOC;
      array_q            <= '0;
      req_q              <= '0;
      allocs_q           <= '0;
      in_use_q           <= '0;
      top_q              <= '0;
      bitmap_q           <= '0;
      rsp_valid_q        <= 1'b0;
      rsp_req_q          <= '0;
      rsp_array_q        <= '0;
      rsp_error_q        <= 1'b0;
      size_clear_q       <= 1'b0;
      size_clear_array_q <= '0;
    end else begin
      state_q            <= state_d;
      op_q               <= op_d;
      array_q            <= array_d;
      req_q              <= req_d;
      allocs_q           <= allocs_d;
      in_use_q           <= in_use_d;
      top_q              <= top_d;
      bitmap_q           <= bitmap_d;
      rsp_valid_q        <= rsp_valid_d;
      rsp_req_q          <= rsp_req_d;
      rsp_array_q        <= rsp_array_d;
      rsp_error_q        <= rsp_error_d;
      size_clear_q       <= size_clear_d;
      size_clear_array_q <= size_clear_array_d;
    end
  end

  // Freed-index stack storage; contents are only meaningful below top.
  always_ff @(posedge clock) begin
    if (!reset && push_en) begin
      assert (top_q < TW'(NArrays));
      freed_q[push_idx] <= push_val;
    end
  end

  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_req          = rsp_req_q;
  assign bus.rsp_array        = rsp_array_q;
  assign bus.rsp_error        = rsp_error_q;
  assign bus.size_clear       = size_clear_q;
  assign bus.size_clear_array = size_clear_array_q;
  assign bus.allocs           = allocs_q;
  assign bus.in_use           = in_use_q;

endmodule

// File: tb/tb_heap_array_allocator.sv
// Directed and random checks of the allocator against a queue-based model.
module tb_heap_array_allocator;
  localparam int NR = 2;
  localparam int NARR = 4;
  localparam int W = 12;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  heap_array_allocator_if #(.NReq(NR), .MemoryElementWidth(W)) bus ();

  heap_array_allocator #(.NReq(NR), .NArrays(NARR), .MemoryElementWidth(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: LIFO of freed indices, bump counter, ownership flags.
  int freed_m[$];
  int allocs_m;
  int in_use_m;
  bit used_m [NARR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    freed_m.delete();
    allocs_m = 0;
    in_use_m = 0;
    for (int i = 0; i < NARR; i++) used_m[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.req_valid = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_size_clear", 32'(bus.size_clear), 0);
    chk("rst_allocs", 32'(bus.allocs), 0);
    chk("rst_in_use", 32'(bus.in_use), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
  endtask

  // Wait (bounded) for any grant; called just after a negedge.
  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (|bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
      #1;
    end
    if (!ok) chk("grant_timeout", 0, 1);
  endtask

  // Model update for one granted op; returns expected index and error.
  task automatic model_op(input bit fr, input int arr, output int exp_arr, output bit exp_err);
    if (!fr) begin
      if (freed_m.size() > 0) begin
        exp_arr = freed_m.pop_back();
        exp_err = 1'b0;
      end else if (allocs_m < NARR) begin
        exp_arr = allocs_m;
        allocs_m++;
        exp_err = 1'b0;
      end else begin
        exp_arr = 0;
        exp_err = 1'b1;
      end
      if (!exp_err) begin
        used_m[exp_arr] = 1'b1;
        in_use_m++;
      end
    end else begin
      exp_arr = arr;
      if (arr >= allocs_m || !used_m[arr]) begin
        exp_err = 1'b1;
      end else begin
        exp_err = 1'b0;
        freed_m.push_back(arr);
        used_m[arr] = 1'b0;
        in_use_m--;
      end
    end
  endtask

  // Check the response two cycles after the grant edge.
  task automatic check_rsp(input int r, input bit fr, input int exp_arr, input bit exp_err);
    int n;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      #1;
      n++;
      if (bus.rsp_valid) break;
    end
    chk("rsp_latency", 32'(n), 2);
    chk("rsp_req", 32'(bus.rsp_req), 32'(r));
    chk("rsp_array", 32'(bus.rsp_array), 32'(exp_arr));
    chk("rsp_error", 32'(bus.rsp_error), 32'(exp_err));
    chk("size_clear", 32'(bus.size_clear), 32'(!fr && !exp_err));
    if (!fr && !exp_err) chk("size_clear_array", 32'(bus.size_clear_array), 32'(exp_arr));
    chk("allocs", 32'(bus.allocs), 32'(allocs_m));
    chk("in_use", 32'(bus.in_use), 32'(in_use_m));
    $display("txn req=%0d op=%s arr=%0d err=%0d allocs=%0d in_use=%0d",
             r, fr ? "free" : "alloc", bus.rsp_array, bus.rsp_error, bus.allocs, bus.in_use);
  endtask

  task automatic do_op(input int r, input bit fr, input int arr);
    bit ok;
    int exp_arr;
    bit exp_err;
    @(negedge clock);
    bus.req_valid[r] = 1'b1;
    bus.req_free[r]  = fr;
    bus.req_array[r*W +: W] = W'(arr);
    #1;
    wait_grant(ok);
    if (!ok) begin
      bus.req_valid = '0;
      return;
    end
    chk("grant_onehot", 32'(bus.req_ready), 32'(1 << r));
    @(posedge clock);
    #1;
    bus.req_valid[r] = 1'b0;
    model_op(fr, arr, exp_arr, exp_err);
    check_rsp(r, fr, exp_arr, exp_err);
  endtask

  initial begin
    bit ok;
    int exp_arr;
    bit exp_err;
    int exp_r;
    bus.req_valid = '0;
    bus.req_free  = '0;
    bus.req_array = '0;

    // Two allocs from requester 0.
    do_reset();
    do_op(0, 0, 0);
    do_op(0, 0, 0);

    // LIFO reuse.
    do_reset();
    do_op(0, 0, 0); do_op(0, 0, 0); do_op(0, 0, 0);
    do_op(0, 1, 1); do_op(1, 1, 0);
    do_op(0, 0, 0); do_op(1, 0, 0);

    // Exhaustion, then reuse.
    do_reset();
    for (int i = 0; i < 5; i++) do_op(0, 0, 0);
    do_op(1, 1, 2);
    do_op(1, 0, 0);

    // Out-of-range free and double free.
    do_reset();
    do_op(0, 0, 0); do_op(0, 0, 0);
    do_op(0, 1, 3);
    do_reset();
    do_op(0, 0, 0); do_op(0, 1, 0); do_op(0, 1, 0);
    do_op(1, 0, 0);

    // Both requesters hold alloc: grants alternate.
    do_reset();
    @(negedge clock);
    bus.req_free  = '0;
    bus.req_valid = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      wait_grant(ok);
      if (!ok) break;
      exp_r = g % 2;
      chk("rr_grant", 32'(bus.req_ready), 32'(1 << exp_r));
      @(posedge clock);
      #1;
      if (g == 3) bus.req_valid = '0;
      model_op(0, 0, exp_arr, exp_err);
      check_rsp(exp_r, 0, exp_arr, exp_err);
      @(negedge clock);
      #1;
    end
    bus.req_valid = '0;

    // Reset during EXEC aborts the op.
    do_reset();
    @(negedge clock);
    bus.req_valid[0] = 1'b1;
    bus.req_free[0]  = 1'b0;
    #1;
    wait_grant(ok);
    @(posedge clock);
    #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1;
      chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("abort_size_clear", 32'(bus.size_clear), 0);
    end
    reset = 1'b0;
    model_reset();
    do_op(0, 0, 0);

    // Random mix against the model.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      do_op(int'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, NARR + 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
